// File: rtl/bsg_manycore_store_arb_pkg.sv
// Shared types for the manycore remote store arbiter.
// Optional statistics build: BSG_MANYCORE_STORE_ARB_STATS_EN.
package bsg_manycore_store_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  localparam int unsigned store_arb_addr_width_gp = 32;
  localparam int unsigned store_arb_data_width_gp = 32;
  localparam int unsigned store_arb_mask_width_gp =
    store_arb_data_width_gp >> 3;

  // Reference request layout; the top re-declares it at its own widths.
  typedef struct packed {
    logic [store_arb_addr_width_gp-1:0] addr;
    logic [store_arb_data_width_gp-1:0] data;
    logic [store_arb_mask_width_gp-1:0] mask;
    logic                               we;
  } store_req_s;

  function automatic int unsigned credit_width(
    input int unsigned max_credits
  );
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/bsg_manycore_store_arb_rr.sv
// Round-robin grant with a rotating priority pointer.
// Pointer moves past the winner only when the grant is taken.
module bsg_manycore_store_arb_rr #(
  parameter  int unsigned num_req_p    = 2,
  localparam int unsigned ptr_width_lp = $clog2(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [num_req_p-1:0] elig_i,
  input  logic                 advance_i,
  output logic [num_req_p-1:0] grant_o
);

  logic [ptr_width_lp-1:0] ptr_q;
  logic [ptr_width_lp-1:0] ptr_d;
  logic [ptr_width_lp-1:0] win;
  logic                    found;
  int                      idx;

  always_comb begin
    grant_o = '0;
    win     = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < int'(num_req_p); off++) begin
      idx = (int'(ptr_q) + off) % int'(num_req_p);
      if (!found && elig_i[idx]) begin
        found = 1'b1;
        win   = ptr_width_lp'(idx);
      end
    end
    if (found) begin
      grant_o[win] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (win == ptr_width_lp'(num_req_p - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win + ptr_width_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bsg_manycore_remote_store_arb.sv
// Round-robin store/load arbiter in front of the packet encoder.
// Optional counters: define BSG_MANYCORE_STORE_ARB_STATS_EN.
module bsg_manycore_remote_store_arb
  import bsg_manycore_store_arb_pkg::*;
#(
  parameter  int unsigned num_req_p         = 2,
  parameter  int unsigned addr_width_p      = 32,
  parameter  int unsigned data_width_p      = 32,
  parameter  int unsigned max_out_credits_p = 16,
  localparam int unsigned mask_width_lp     = data_width_p >> 3,
  localparam int unsigned credit_width_lp   =
    credit_width(max_out_credits_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  input  logic [num_req_p*mask_width_lp-1:0] req_mask_i,
  input  logic [num_req_p-1:0]              req_we_i,
  output logic [num_req_p-1:0]              req_yumi_o,
  output logic                              enc_v_o,
  output logic [addr_width_p-1:0]           enc_addr_o,
  output logic [data_width_p-1:0]           enc_data_o,
  output logic [mask_width_lp-1:0]          enc_mask_o,
  output logic                              enc_we_o,
  input  logic                              enc_ready_i,
  input  logic                              credit_v_i,
  output logic [credit_width_lp-1:0]        out_credits_o,
`ifdef BSG_MANYCORE_STORE_ARB_STATS_EN
  output logic [31:0]                       stall_cycles_o,
  output logic [num_req_p*32-1:0]           grant_cnt_o,
`endif
  output logic                              credit_err_o
);

  typedef struct packed {
    logic [addr_width_p-1:0]  addr;
    logic [data_width_p-1:0]  data;
    logic [mask_width_lp-1:0] mask;
    logic                     we;
  } req_s;

  localparam int unsigned cw1_lp = credit_width_lp + 1;
  localparam logic [credit_width_lp-1:0] credit_max_lp =
    credit_width_lp'(max_out_credits_p);

  arb_state_e state_q;
  arb_state_e state_d;
  req_s       pkt_q;
  req_s       pkt_d;
  req_s       sel_pkt;

  logic [credit_width_lp-1:0] credits_q;
  logic [credit_width_lp-1:0] credits_d;
  logic                       err_q;
  logic                       err_d;

  logic [num_req_p-1:0] elig;
  logic [num_req_p-1:0] grant;
  logic [num_req_p-1:0] yumi;
  logic                 can_grant;
  logic                 send_fire;
  logic                 store_fire;
  logic                 credit_ok;

  assign send_fire  = (state_q == SEND) & enc_ready_i;
  assign store_fire = send_fire & pkt_q.we;

  // The store leaving this cycle still owns a credit; count it as spent.
  assign credit_ok =
    ({1'b0, credits_q} + cw1_lp'(credit_v_i)) > cw1_lp'(store_fire);

  assign elig = req_v_i & (~req_we_i | {num_req_p{credit_ok}});

  assign can_grant = (state_q == IDLE) | enc_ready_i;
  assign yumi      = grant & {num_req_p{can_grant}};

  bsg_manycore_store_arb_rr #(
    .num_req_p(num_req_p)
  ) u_rr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .elig_i   (elig),
    .advance_i(|yumi),
    .grant_o  (grant)
  );

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < int'(num_req_p); i++) begin
      if (yumi[i]) begin
        sel_pkt.addr =
          req_addr_i[i*addr_width_p +: addr_width_p];
        sel_pkt.data =
          req_data_i[i*data_width_p +: data_width_p];
        sel_pkt.mask =
          req_mask_i[i*mask_width_lp +: mask_width_lp];
        sel_pkt.we   = req_we_i[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    if (|yumi) begin
      pkt_d   = sel_pkt;
      state_d = SEND;
    end else if (send_fire) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    unique case ({credit_v_i, store_fire})
      2'b10: begin
        if (credits_q == credit_max_lp) begin
          err_d = 1'b1;
        end else begin
          credits_d = credits_q + credit_width_lp'(1);
        end
      end
      2'b01: credits_d = credits_q - credit_width_lp'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      pkt_q     <= '0;
      credits_q <= credit_max_lp;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign req_yumi_o    = yumi;
  assign enc_v_o       = (state_q == SEND);
  assign enc_addr_o    = pkt_q.addr;
  assign enc_data_o    = pkt_q.data;
  assign enc_mask_o    = pkt_q.mask;
  assign enc_we_o      = pkt_q.we;
  assign out_credits_o = credits_q;
  assign credit_err_o  = err_q;

`ifdef BSG_MANYCORE_STORE_ARB_STATS_EN
  logic [31:0]                stall_q;
  logic [31:0]                stall_d;
  logic [num_req_p-1:0][31:0] gcnt_q;
  logic [num_req_p-1:0][31:0] gcnt_d;

  always_comb begin
    stall_d = stall_q;
    gcnt_d  = gcnt_q;
    if ((state_q == SEND) && !enc_ready_i) begin
      stall_d = stall_q + 32'd1;
    end
    for (int i = 0; i < int'(num_req_p); i++) begin
      if (yumi[i]) begin
        gcnt_d[i] = gcnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_q <= '0;
      gcnt_q  <= '0;
    end else begin
      stall_q <= stall_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign grant_cnt_o    = gcnt_q;
`endif

endmodule
